// File: rtl/fpu_pkg.sv
// Shared single-precision float field definitions, rounding modes and the
// operand classes produced by the decode stage of ftoi_multi.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int MANT_W = FRAC_W + 1;
  // Fraction bits kept after alignment: the whole mantissa still fits at
  // unbiased exponent -3, below which only the sticky bit matters.
  localparam int FRAC_EXT = 26;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RDN = 2'b10,
    RUP = 2'b11
  } rmode_t;

  typedef enum logic [1:0] {
    CLS_NUM   = 2'b00,
    CLS_FLUSH = 2'b01,
    CLS_NAN   = 2'b10,
    CLS_OVF   = 2'b11
  } fcls_t;

endpackage

// File: rtl/ftoi_round.sv
// Stage-2 rounding: turns guard/round/sticky, sign and mode into an
// increment and applies it to the truncated magnitude.
module ftoi_round
  import fpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] mag,
  input  logic         g,
  input  logic         r,
  input  logic         s,
  input  logic         sign,
  input  logic         en,
  input  rmode_t       rmode,
  output logic [W:0]   mag_r
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    unique case (rmode)
      RNE: inc = g & (r | s | mag[0]);
      RTZ: inc = 1'b0;
      RDN: inc = sign & (g | r | s);
      RUP: inc = ~sign & (g | r | s);
    endcase
    mag_r = {1'b0, mag} + {{W{1'b0}}, inc & en};
  end

endmodule

// File: rtl/ftoi_multi.sv
// Two-stage float32 -> integer converter with valid/ready handshakes.
// Define FTOI_MULTI_FLAGS_EN to add the {invalid, inexact} flags port.
module ftoi_multi
  import fpu_pkg::*;
#(
  parameter int OUT_W   = 32,
  parameter int HOLD_IN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      op,
  input  logic [1:0]       rmode,
  input  logic             is_signed,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] result,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FTOI_MULTI_FLAGS_EN
  ,
  output logic [1:0]       flags
`endif
);

  localparam int WIDE_W = OUT_W + FRAC_EXT;
  localparam logic [OUT_W-1:0] UMAX = '1;
  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W:0]   NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic             sign;
    logic             is_signed;
    rmode_t           rmode;
    fcls_t            cls;
    logic [OUT_W-1:0] mag;
    logic             g;
    logic             r;
    logic             s;
  } s1_t;

  s1_t s1_d, s1_q;
  logic v1_d, v1_q, v2_d, v2_q;
  logic advance, s1_load, res_load;

  // ---------------- control ----------------
  always_comb begin
    advance  = ~v2_q | out_ready;
    v1_d     = advance ? in_valid : v1_q;
    v2_d     = advance ? v1_q : v2_q;
    s1_load  = advance & (in_valid | (HOLD_IN == 0));
    res_load = advance & v1_q;
  end

  assign in_ready  = advance;
  assign out_valid = v2_q;

  // ---------------- S1: decode / align ----------------
  logic [EXP_W-1:0]  ex;
  logic [FRAC_W-1:0] fr;
  logic [WIDE_W-1:0] wide;
  int                ue;

  always_comb begin
    ex   = op[FRAC_W +: EXP_W];
    fr   = op[FRAC_W-1:0];
    ue   = int'(ex) - BIAS;
    wide = '0;
    s1_d = '0;
    s1_d.sign      = op[31];
    s1_d.is_signed = is_signed;
    s1_d.rmode     = rmode_t'(rmode);
    if (ex == '0) begin
      s1_d.cls = CLS_FLUSH;
      s1_d.s   = |fr;
    end else if (&ex) begin
      s1_d.cls = (|fr) ? CLS_NAN : CLS_OVF;
    end else if (ue >= OUT_W) begin
      s1_d.cls = CLS_OVF;
    end else if (ue < -3) begin
      // Below 1/8 the whole value lands in the sticky bit.
      s1_d.cls = CLS_NUM;
      s1_d.s   = 1'b1;
    end else begin
      // Integer LSB sits at bit FRAC_EXT; mantissa LSB weighs 2^(ue-23).
      s1_d.cls = CLS_NUM;
      wide     = WIDE_W'({1'b1, fr}) << 7'(ue + 3);
      s1_d.mag = wide[WIDE_W-1 -: OUT_W];
      s1_d.g   = wide[FRAC_EXT-1];
      s1_d.r   = wide[FRAC_EXT-2];
      s1_d.s   = |wide[FRAC_EXT-3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (s1_load) s1_q <= s1_d;
    end
  end

  // ---------------- S2: round / saturate ----------------
  logic [OUT_W:0]   mag_r;
  logic [OUT_W-1:0] conv, sat_val, result_d, result_q;
  logic             ovf_num, sat;

  ftoi_round #(.W(OUT_W)) u_round (
    .mag   (s1_q.mag),
    .g     (s1_q.g),
    .r     (s1_q.r),
    .s     (s1_q.s),
    .sign  (s1_q.sign),
    .en    (s1_q.cls == CLS_NUM),
    .rmode (s1_q.rmode),
    .mag_r (mag_r)
  );

  always_comb begin
    if (s1_q.is_signed)
      ovf_num = s1_q.sign ? (mag_r > NEG_LIM) : (mag_r[OUT_W] | mag_r[OUT_W-1]);
    else
      ovf_num = s1_q.sign ? (|mag_r) : mag_r[OUT_W];

    sat = (s1_q.cls == CLS_NAN) | (s1_q.cls == CLS_OVF) |
          ((s1_q.cls == CLS_NUM) & ovf_num);

    // NaN goes to the positive limit; everything else saturates by sign.
    if (s1_q.cls != CLS_NAN && s1_q.sign)
      sat_val = s1_q.is_signed ? SMIN : '0;
    else
      sat_val = s1_q.is_signed ? SMAX : UMAX;

    conv     = (s1_q.is_signed && s1_q.sign) ? (-mag_r[OUT_W-1:0]) : mag_r[OUT_W-1:0];
    result_d = sat ? sat_val : conv;
  end

  always_ff @(posedge clk) begin
    if (reset) result_q <= '0;
    else if (res_load) result_q <= result_d;
  end

  assign result = result_q;

`ifdef FTOI_MULTI_FLAGS_EN
  logic [1:0] flags_d, flags_q;

  always_comb flags_d = {sat, (s1_q.g | s1_q.r | s1_q.s) & ~sat};

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else if (res_load) flags_q <= flags_d;
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_ftoi_multi.sv
// Bench for ftoi_multi: directed table, stall/reset sequences and a random
// sweep on 16/32/64-bit instances against a real-arithmetic reference model.
module tb_ftoi_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op = '0;
  logic [1:0]  rmode = '0;
  logic        is_signed = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        ir16, ir32, ir64, ov16, ov32, ov64;
  logic [15:0] res16;
  logic [31:0] res32;
  logic [63:0] res64;
`ifdef FTOI_MULTI_FLAGS_EN
  logic [1:0]  fl16, fl32, fl64;
`endif

  always #5 clk = ~clk;

  ftoi_multi #(.OUT_W(16)) dut16 (
    .clk(clk), .reset(reset), .op(op), .rmode(rmode), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(ir16), .result(res16), .out_valid(ov16),
    .out_ready(out_ready)
`ifdef FTOI_MULTI_FLAGS_EN
    , .flags(fl16)
`endif
  );

  ftoi_multi #(.OUT_W(32)) dut32 (
    .clk(clk), .reset(reset), .op(op), .rmode(rmode), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(ir32), .result(res32), .out_valid(ov32),
    .out_ready(out_ready)
`ifdef FTOI_MULTI_FLAGS_EN
    , .flags(fl32)
`endif
  );

  ftoi_multi #(.OUT_W(64), .HOLD_IN(1)) dut64 (
    .clk(clk), .reset(reset), .op(op), .rmode(rmode), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(ir64), .result(res64), .out_valid(ov64),
    .out_ready(out_ready)
`ifdef FTOI_MULTI_FLAGS_EN
    , .flags(fl64)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int e);
    real p = 1.0;
    if (e >= 0) repeat (e) p = p * 2.0;
    else repeat (-e) p = p / 2.0;
    return p;
  endfunction

  // Returns {invalid, inexact, result[63:0]} for a W-bit conversion.
  function automatic logic [65:0] model(input logic [31:0] f, input logic [1:0] rm,
                                        input logic sg, input int w);
    logic [63:0] mask, umax, smax, smin, res;
    logic        inv, inx;
    int          ex;
    real         v, r, fl, lim;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    umax = mask;
    smax = mask >> 1;
    smin = smax + 64'd1;
    ex   = int'(f[30:23]);
    inv  = 1'b0;
    inx  = 1'b0;
    res  = '0;
    if (ex == 255) begin
      inv = 1'b1;
      if (f[22:0] != 0 || !f[31]) res = sg ? smax : umax;
      else res = sg ? smin : 64'd0;
    end else if (ex == 0) begin
      inx = (f[22:0] != 0);
    end else begin
      v = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(ex - 127);
      if (f[31]) v = -v;
      fl = $floor(v);
      case (rm)
        2'd0: begin
          if (v - fl > 0.5) r = fl + 1.0;
          else if (v - fl < 0.5) r = fl;
          else r = (fl - 2.0 * $floor(fl / 2.0) != 0.0) ? fl + 1.0 : fl;
        end
        2'd1: r = (v < 0.0) ? $ceil(v) : fl;
        2'd2: r = fl;
        default: r = $ceil(v);
      endcase
      lim = pow2(sg ? w - 1 : w);
      if (r >= lim) begin
        inv = 1'b1; res = sg ? smax : umax;
      end else if (sg ? (r < -lim) : (r < 0.0)) begin
        inv = 1'b1; res = sg ? smin : 64'd0;
      end else begin
        if (r >= pow2(63)) res = 64'(longint'(r - pow2(63))) | (64'd1 << 63);
        else res = 64'(longint'(r));
        res = res & mask;
        inx = (r != v);
      end
    end
    return {inv, inx, res};
  endfunction

  typedef struct packed {
    logic [63:0] r16, r32, r64;
    logic [1:0]  f16, f32, f64;
  } exp_t;

  typedef struct packed {
    logic [31:0] op;
    logic [1:0]  rm;
    logic        sg;
  } txn_t;

  function automatic exp_t expect_of(input txn_t t);
    exp_t e;
    logic [65:0] m;
    m = model(t.op, t.rm, t.sg, 16); e.r16 = m[63:0]; e.f16 = m[65:64];
    m = model(t.op, t.rm, t.sg, 32); e.r32 = m[63:0]; e.f32 = m[65:64];
    m = model(t.op, t.rm, t.sg, 64); e.r64 = m[63:0]; e.f64 = m[65:64];
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] fr, m;
    fr = 23'($urandom);
    m  = 23'h7FFFFF;
    if ($urandom_range(0, 2) == 0) fr = fr & (m << $urandom_range(0, 23));
    case ($urandom_range(0, 9))
      0: e = 8'($urandom);
      1: e = 8'd0;
      2: e = 8'hFF;
      default: e = 8'(110 + $urandom_range(0, 85));
    endcase
    return {1'($urandom), e, fr};
  endfunction

  // ---------------- streaming scoreboard ----------------
  txn_t src_q[$];
  exp_t sbq[$];

  task automatic run_stream(input bit rnd, input int stall_lo, input int stall_hi);
    int          cyc = 0;
    int          budget = src_q.size() * 20 + 100;
    bit          pend = 0;
    bit          prev_stall = 0;
    logic [63:0] p16 = '0, p32 = '0, p64 = '0;
    txn_t        cur = '0;
    exp_t        e;
    while ((src_q.size() > 0 || pend || sbq.size() > 0) && cyc < budget) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_out_valid", ov32, 1);
        chk("hold_res16", res16, p16);
        chk("hold_res32", res32, p32);
        chk("hold_res64", res64, p64);
      end
      if (!pend && src_q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        cur  = src_q.pop_front();
        pend = 1;
      end
      in_valid  = pend;
      op        = pend ? cur.op : $urandom;
      rmode     = pend ? cur.rm : 2'($urandom);
      is_signed = pend ? cur.sg : 1'($urandom);
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_lo && cyc <= stall_hi);
      #1;
      if (ov32 && !out_ready) chk("stall_in_ready", ir32, 0);
      if (ov32 && out_ready) begin
        if (sbq.size() == 0) chk("spurious_out_valid", ov32, 0);
        else begin
          e = sbq.pop_front();
          chk("out_valid_16_64", {ov16, ov64}, 2'b11);
          chk("res16", res16, e.r16);
          chk("res32", res32, e.r32);
          chk("res64", res64, e.r64);
`ifdef FTOI_MULTI_FLAGS_EN
          chk("flags16", fl16, e.f16);
          chk("flags32", fl32, e.f32);
          chk("flags64", fl64, e.f64);
`endif
        end
      end
      if (in_valid && ir32) begin
        sbq.push_back(expect_of(cur));
        pend = 0;
      end
      prev_stall = ov32 && !out_ready;
      p16 = res16; p32 = res32; p64 = res64;
      cyc++;
    end
    chk("stream_drained", src_q.size() + sbq.size() + int'(pend), 0);
    src_q.delete();
    sbq.delete();
    in_valid  = 0;
    out_ready = 1;
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [31:0] op;
    logic [1:0]  rm;
    logic        sg;
    logic [31:0] r32;
    logic [1:0]  fl;
  } vec_t;

  vec_t vt[17];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'h3FC00000, 2'd0, 1'b1, 32'h00000002, 2'b01};
    vt[1]  = '{32'h3FC00000, 2'd1, 1'b1, 32'h00000001, 2'b01};
    vt[2]  = '{32'h40200000, 2'd0, 1'b1, 32'h00000002, 2'b01};
    vt[3]  = '{32'hBFC00000, 2'd2, 1'b1, 32'hFFFFFFFE, 2'b01};
    vt[4]  = '{32'hBFC00000, 2'd3, 1'b1, 32'hFFFFFFFF, 2'b01};
    vt[5]  = '{32'h4F000000, 2'd0, 1'b1, 32'h7FFFFFFF, 2'b10};
    vt[6]  = '{32'h4F000000, 2'd0, 1'b0, 32'h80000000, 2'b00};
    vt[7]  = '{32'h7FC00000, 2'd0, 1'b1, 32'h7FFFFFFF, 2'b10};
    vt[8]  = '{32'hBF000000, 2'd1, 1'b0, 32'h00000000, 2'b01};
    vt[9]  = '{32'hCF000000, 2'd0, 1'b1, 32'h80000000, 2'b00};
    vt[10] = '{32'h00000001, 2'd3, 1'b1, 32'h00000000, 2'b01};
    vt[11] = '{32'h80000000, 2'd0, 1'b1, 32'h00000000, 2'b00};
    vt[12] = '{32'hFF800000, 2'd0, 1'b0, 32'h00000000, 2'b10};
    vt[13] = '{32'h7F800000, 2'd0, 1'b0, 32'hFFFFFFFF, 2'b10};
    vt[14] = '{32'h3F400000, 2'd0, 1'b1, 32'h00000001, 2'b01};
    vt[15] = '{32'h3F000000, 2'd0, 1'b1, 32'h00000000, 2'b01};
    vt[16] = '{32'h4B000001, 2'd0, 1'b1, 32'h00800001, 2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {ov16, ov32, ov64}, 3'b000);
    chk("rst_res32", res32, 0);
    chk("rst_res64", res64, 0);
`ifdef FTOI_MULTI_FLAGS_EN
    chk("rst_flags32", fl32, 0);
`endif
    reset = 0;
    out_ready = 1;
    @(negedge clk);
    chk("post_rst_in_ready", ir32, 1);

    // Directed vectors, one at a time, with latency check
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      op = vt[i].op; rmode = vt[i].rm; is_signed = vt[i].sg; in_valid = 1;
      #1 chk($sformatf("dir%0d_in_ready", i), ir32, 1);
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("dir%0d_lat1_valid", i), ov32, 0);
      @(negedge clk);
      chk($sformatf("dir%0d_lat2_valid", i), ov32, 1);
      chk($sformatf("dir%0d_res32", i), res32, vt[i].r32);
`ifdef FTOI_MULTI_FLAGS_EN
      chk($sformatf("dir%0d_flags32", i), fl32, vt[i].fl);
`endif
    end

    // Four back-to-back ops, out_ready low for 3 cycles from first result
    for (int i = 1; i <= 4; i++) begin
      txn_t t;
      t.op = {1'b0, 8'(127 + i / 2), 23'(i == 3 ? 23'h400000 : 23'h0)};
      t.rm = 2'd0;
      t.sg = 1'b1;
      src_q.push_back(t);
    end
    run_stream(0, 2, 4);

    // Reset with two transactions in flight, stalled output
    @(negedge clk);
    out_ready = 0; in_valid = 1; op = 32'h3F800000; rmode = 0; is_signed = 1;
    @(negedge clk);
    op = 32'h40000000;
    @(negedge clk);
    chk("pre_rst_valid", ov32, 1);
    op = 32'h40400000;
    reset = 1;
    @(negedge clk);
    chk("mid_rst_out_valid", ov32, 0);
    chk("mid_rst_res32", res32, 0);
`ifdef FTOI_MULTI_FLAGS_EN
    chk("mid_rst_flags32", fl32, 0);
`endif
    @(negedge clk);
    reset = 0; in_valid = 0; out_ready = 1;
    #1 chk("rst_release_in_ready", ir32, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst_no_emit%0d", i), ov32, 0);
    end

    // Random sweep
    for (int i = 0; i < 10000; i++) begin
      txn_t t;
      t.op = rand_op();
      t.rm = 2'($urandom);
      t.sg = 1'($urandom);
      src_q.push_back(t);
    end
    run_stream(1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ftoi_multi.md
FTOI_MULTI -- requirements
Module: ftoi_multi

Interface
REQ-001 SHALL provide parameter OUT_W, default 32, integer result width (legal 8..64).
REQ-002 SHALL provide parameter HOLD_IN, default 0, 1 = stage-1 register keeps last op when idle (debug aid, no functional effect on outputs).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port op  input  32  IEEE-754 single operand.
REQ-006 SHALL have port rmode  input  2  rounding: 00 RNE, 01 RTZ, 10 RDN, 11 RUP.
REQ-007 SHALL have port is_signed  input  1  1 = two's-complement result, 0 = unsigned.
REQ-008 SHALL have ports in_valid  input  1 and in_ready  output  1  input handshake.
REQ-009 SHALL have port result  output  OUT_W  converted integer.
REQ-010 SHALL have ports out_valid  output  1 and out_ready  input  1  output handshake.
REQ-011 SHALL have port flags  output  2  {invalid, inexact}, present only per REQ-030.

Function
REQ-012 SHALL transfer an input when in_valid && in_ready, an output when out_valid && out_ready.
REQ-013 SHALL be a 2-stage pipeline: S1 decode/align, S2 round/saturate; latency exactly 2 cycles from accepted input to out_valid with no stall.
REQ-014 SHALL compute advance = !v2 || out_ready; in_ready = advance; both stages load only when advance.
REQ-015 SHALL sustain 1 result/cycle while out_ready stays high.
REQ-016 SHALL hold result, flags, out_valid stable while out_valid && !out_ready.
REQ-017 SHALL carry rmode and is_signed with the operand through the pipe (per-transaction mode).
REQ-018 SHALL flush exponent-zero inputs (zero, denormals) to result 0, inexact = 1 only for denormals.
REQ-019 SHALL round the exact value per rmode; RNE ties to even; RDN/RUP act on signed value.
REQ-020 SHALL saturate signed overflow to 2^(OUT_W-1)-1 / -2^(OUT_W-1), unsigned to 2^OUT_W-1 / 0.
REQ-021 SHALL map NaN to the signed or unsigned maximum, +Inf to max, -Inf to min (signed) or 0 (unsigned).
REQ-022 SHALL treat a negative value rounding to 0 in unsigned mode as 0, not invalid (inexact only).
REQ-023 SHALL set invalid on NaN, Inf, or saturation; inexact on any discarded nonzero fraction when not invalid.
REQ-024 SHALL give -2^(OUT_W-1) exactly (e.g. 0xCF000000, OUT_W=32) as a valid non-saturated result.

Reset
REQ-025 SHALL clear v1, v2, out_valid to 0 and result, flags to 0 on reset, regardless of stall.
REQ-026 SHALL discard in-flight transactions on reset mid-operation; in_ready = 1 the cycle after reset deasserts.
REQ-027 SHALL ignore in_valid while reset is high.

Configuration
REQ-028 SHALL use macro FTOI_MULTI_FLAGS_EN.
REQ-029 Without it SHALL omit flags port and flag logic; saturation behaviour unchanged.
REQ-030 With it SHALL include flags port and S2 flag registers per REQ-023.

Structure
REQ-031 SHALL place rmode_t enum (RNE, RTZ, RDN, RUP) and float field widths (EXP_W=8, FRAC_W=23, BIAS=127) in package fpu_pkg.
REQ-032 SHALL isolate stage-2 rounding in sub-module ftoi_round (guard/round/sticky, sign, rmode -> increment).
REQ-033 SHALL keep control (valids, advance) in ftoi_multi top.

Verification
REQ-034 0x3FC00000 (1.5), RNE -> 0x00000002; RTZ -> 0x00000001; inexact = 1, out_valid 2 cycles after accept.
REQ-035 0x40200000 (2.5), RNE -> 0x00000002; 0xBFC00000 (-1.5), RDN -> 0xFFFFFFFE, RUP -> 0xFFFFFFFF.
REQ-036 0x4F000000 (2^31), signed, OUT_W=32 -> 0x7FFFFFFF, invalid = 1; unsigned -> 0x80000000, invalid = 0.
REQ-037 0x7FC00000 NaN signed -> 0x7FFFFFFF invalid; 0xBF000000 (-0.5) unsigned RTZ -> 0, invalid 0, inexact 1.
REQ-038 Back-to-back 4 inputs, out_ready low 3 cycles after first result -> result held, in_ready low while both stages full, no loss or duplication.
REQ-039 reset pulsed with 2 transactions in flight -> out_valid 0 next cycle, neither result ever emitted; random sweep of 10000 ops vs. reference model, OUT_W 16/32/64.
